card_reader_rx: RTL
===================

# card_reader_rx

Serial card-reader front end for the metro turnstile. It receives a framed serial code from the card reader head and decodes the 4-bit access code. It checks parity and stop bit, then delivers the code to the turnstile controller as a held `access_code` plus a one-cycle `validate_code` pulse. Frames that arrive while the door is open are dropped and flagged; malformed frames are flagged and discarded.

## Interface
- `CLKS_PER_BIT`, default 16: clocks per serial bit period; legal values are ≥ 4. `HALF` = `CLKS_PER_BIT/2`, using integer division.
- `clk`  input  1  system clock, rising-edge active
- `rst_n`  input  1  asynchronous, active-low reset
- `card_rx`  input  1  serial line from reader head; asynchronous, idles high
- `door_busy`  input  1  high while the turnstile door is open (the controller's `open_access_door`)
- `access_code`  output  4  last accepted code; held until the next accepted frame
- `validate_code`  output  1  one-cycle pulse: `access_code` is new and valid
- `frame_error`  output  1  one-cycle pulse: parity or stop-bit failure
- `code_dropped`  output  1  one-cycle pulse: good frame discarded because `door_busy` was high
- `state_out`  output  3  current FSM state, for debug

## Operation
- Frame format, in line order: start bit (0), data bits d0..d3 (LSB first), even parity bit p, stop bit (1). A frame is good when d0^d1^d2^d3^p = 0.
- `card_rx` passes through a 2-flop synchronizer to produce `rx_s`. Both flops reset to 1. All FSM decisions use `rx_s` only.
- State encoding: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, RECOVER=5. Unused encodings go to IDLE.
- A bit counter `cnt` is sized to hold `CLKS_PER_BIT-1`. A 2-bit data index tracks d0..d3. A 4-bit shift register collects the data bits.
- IDLE: when `rx_s`=0, go to START with `cnt`=0.
- START: increment `cnt`. At `cnt`=`HALF-1`:
  - if `rx_s`=0, go to DATA with `cnt`=0 and index=0;
  - otherwise the low pulse was a glitch: return to IDLE with no output.
- DATA: at `cnt`=`CLKS_PER_BIT-1`, store `rx_s` into data bit [index] and reset `cnt` to 0. After d3 is stored, go to PARITY.
- PARITY: at `cnt`=`CLKS_PER_BIT-1`, latch `rx_s` as p and go to STOP.
- STOP: at `cnt`=`CLKS_PER_BIT-1` (the stop-sample cycle), evaluate in priority order:
  1. Stop bit = 0 or parity bad: pulse `frame_error`.
  2. Otherwise, if `door_busy`=1: pulse `code_dropped`.
  3. Otherwise: load `access_code` from the shift register and pulse `validate_code`.
- After the stop-sample cycle, go to IDLE if `rx_s`=1, otherwise go to RECOVER.
- RECOVER: wait for `rx_s`=1, then go to IDLE. No pulses are raised while waiting, so a line held low produces exactly one `frame_error`.
- `door_busy` is sampled only in the stop-sample cycle. Changes to it mid-frame have no effect.
- At most one of the three pulses is high in any cycle.
- `access_code` changes only on an accepted frame. Rejected and dropped frames leave it untouched.

## Timing
- Reset values: `access_code`=0, `validate_code`=0, `frame_error`=0, `code_dropped`=0, `state_out`=0 (IDLE). Synchronizer flops reset to 1.
- An asserted `rst_n` mid-frame aborts the frame immediately. There is no pulse on release, and the FSM restarts in IDLE.
- All outputs are registered. Pulses and the `access_code` update appear in the cycle after the stop-sample edge. `access_code` is therefore already valid while `validate_code` is high.
- Let t0 be the first cycle in which IDLE sees `rx_s`=0:
  - the start bit is sampled at t0+`HALF`;
  - data bit k is sampled at t0+`HALF`+(k+1)·`CLKS_PER_BIT`;
  - the stop bit is sampled at t0+`HALF`+6·`CLKS_PER_BIT`;
  - the output pulse appears at t0+`HALF`+6·`CLKS_PER_BIT`+1.
- Pin-to-`rx_s` latency is 2 cycles.
- With the default `CLKS_PER_BIT`=16, the pulse appears at t0+105.
- Back-to-back frames are accepted: a start bit seen in the cycle right after a successful stop sample begins a new frame.

## Test plan
- Reset: hold `rst_n`=0 with `card_rx` toggling -> all outputs 0 and `state_out`=0. After release, no pulse occurs without a valid start bit.
- Good frame with data 4'd7 (d0..d3 = 1,1,1,0), p=1, stop=1, `door_busy`=0 -> `validate_code` high for exactly one cycle at t0+105 and `access_code`=7. `access_code` remains 7 afterwards.
- Parity error, data 4'd5 sent with p=1 -> `frame_error` pulses once, no `validate_code`, `access_code` stays 7.
- Glitch: `card_rx` low for 3 cycles, then high -> FSM returns to IDLE from START with no pulses. A following good frame with 4'd4 is accepted normally.
- Busy: good frame with 4'd9 while `door_busy`=1 at the stop sample -> `code_dropped` pulses once, no `validate_code`, `access_code` unchanged.
- Break and recovery: stop bit = 0 and line held low for 40 cycles -> one `frame_error`, `state_out`=5 until the line goes high. A next good frame with 4'd11 is accepted. A separate run asserts `rst_n` mid-DATA -> immediate IDLE and no pulse.

Source files
------------

// File: rtl/card_reader_rx_if.sv
// Signal bundle between the card reader head / turnstile controller and the
// card_reader_rx front end.
interface card_reader_rx_if;
   logic       card_rx;
   logic       door_busy;
   logic [3:0] access_code;
   logic       validate_code;
   logic       frame_error;
   logic       code_dropped;
   logic [2:0] state_out;

   modport master (
      output card_rx, door_busy,
      input  access_code, validate_code, frame_error, code_dropped, state_out
   );

   modport slave (
      input  card_rx, door_busy,
      output access_code, validate_code, frame_error, code_dropped, state_out
   );
endinterface

// File: rtl/card_reader_rx.sv
// Serial card-reader receiver: deframes start/4 data/even parity/stop and
// hands the access code to the turnstile controller with one-cycle status pulses.
module card_reader_rx #(
   parameter int CLKS_PER_BIT = 16
) (
   input logic              clk,
   input logic              rst_n,
   card_reader_rx_if.slave  bus
);
   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int CW   = $clog2(CLKS_PER_BIT);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
      PARITY  = 3'd3,
      STOP    = 3'd4,
      RECOVER = 3'd5
   } state_t;

   state_t        state, state_d;
   logic          sync1, rx_s;
   logic [CW-1:0] cnt, cnt_d;
   logic [1:0]    idx, idx_d;
   logic [3:0]    shreg, shreg_d;
   logic          par, par_d;
   logic [3:0]    code, code_d;
   logic          valid, valid_d;
   logic          ferr, ferr_d;
   logic          drop, drop_d;
   logic          bit_end, half_end;

   // The line is asynchronous; it idles high, so the synchronizer resets to 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         sync1 <= bus.card_rx;
         rx_s  <= sync1;
      end
   end

   assign bit_end  = (cnt == CW'(CLKS_PER_BIT - 1));
   assign half_end = (cnt == CW'(HALF - 1));

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      idx_d   = idx;
      shreg_d = shreg;
      par_d   = par;
      code_d  = code;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      drop_d  = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               cnt_d   = '0;
            end
         end
         START: begin
            cnt_d = cnt + CW'(1);
            if (half_end) begin
               cnt_d = '0;
               if (!rx_s) begin
                  state_d = DATA;
                  idx_d   = 2'd0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DATA: begin
            cnt_d = cnt + CW'(1);
            if (bit_end) begin
               cnt_d        = '0;
               shreg_d[idx] = rx_s;
               idx_d        = idx + 2'd1;
               if (idx == 2'd3) state_d = PARITY;
            end
         end
         PARITY: begin
            cnt_d = cnt + CW'(1);
            if (bit_end) begin
               cnt_d   = '0;
               par_d   = rx_s;
               state_d = STOP;
            end
         end
         STOP: begin
            cnt_d = cnt + CW'(1);
            if (bit_end) begin
               cnt_d = '0;
               // Line faults outrank a busy door; a busy door only drops good frames.
               if (!rx_s || ((^shreg) ^ par)) begin
                  ferr_d = 1'b1;
               end else if (bus.door_busy) begin
                  drop_d = 1'b1;
               end else begin
                  code_d  = shreg;
                  valid_d = 1'b1;
               end
               state_d = rx_s ? IDLE : RECOVER;
            end
         end
         RECOVER: begin
            if (rx_s) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= 2'd0;
         shreg <= 4'd0;
         par   <= 1'b0;
         code  <= 4'd0;
         valid <= 1'b0;
         ferr  <= 1'b0;
         drop  <= 1'b0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         idx   <= idx_d;
         shreg <= shreg_d;
         par   <= par_d;
         code  <= code_d;
         valid <= valid_d;
         ferr  <= ferr_d;
         drop  <= drop_d;
      end
   end

   assign bus.access_code   = code;
   assign bus.validate_code = valid;
   assign bus.frame_error   = ferr;
   assign bus.code_dropped  = drop;
   assign bus.state_out     = state;
endmodule
